// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: register/data widths and the writeback entry record.
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] regnum;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/mips_wb_fwd_match.sv
// Youngest-first forwarding search over the occupied region of the writeback queue.
module mips_wb_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [$clog2(DEPTH)-1:0] i_head,
    input  logic [$clog2(DEPTH):0]   i_count,
    input  logic [REG_ADDR_W-1:0]    i_reg,
    input  wb_entry_t                i_entries [DEPTH],
    output logic                     o_hit,
    output logic [DATA_W-1:0]        o_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              w_match [DEPTH];
    logic [DATA_W-1:0] w_data  [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            // gi is the age offset from head: 0 is the oldest pending entry
            wb_entry_t w_ent;
            assign w_ent        = i_entries[i_head + PTR_W'(gi)];
            assign w_match[gi]  = (CNT_W'(gi) < i_count) && (i_reg != ZERO_REG) &&
                                  (w_ent.regnum == i_reg);
            assign w_data[gi]   = w_ent.data;
        end
    endgenerate

    // Later (younger) matches override earlier ones.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_match[k]) begin
                o_hit  = 1'b1;
                o_data = w_data[k];
            end
        end
    end
endmodule

// File: rtl/mips_writeback_buffer.sv
// Dual-lane in-order writeback queue feeding a two-write-port register file,
// with youngest-match forwarding lookups for decode.
module mips_writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inValid1,
    input  logic                     inValid2,
    input  logic [ADDR_W-1:0]        inReg1,
    input  logic [ADDR_W-1:0]        inReg2,
    input  logic [DATA_W-1:0]        inData1,
    input  logic [DATA_W-1:0]        inData2,
    output logic                     inReady,
    output logic                     RegWriteSign1,
    output logic                     RegWriteSign2,
    output logic [ADDR_W-1:0]        writeReg1,
    output logic [ADDR_W-1:0]        writeReg2,
    output logic [DATA_W-1:0]        writeData1,
    output logic [DATA_W-1:0]        writeData2,
    input  logic [ADDR_W-1:0]        fwdReg1,
    input  logic [ADDR_W-1:0]        fwdReg2,
    output logic                     fwdHit1,
    output logic                     fwdHit2,
    output logic [DATA_W-1:0]        fwdData1,
    output logic [DATA_W-1:0]        fwdData2,
    output logic [$clog2(DEPTH):0]   count
);
    import mips_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] ACCEPT_MAX = CNT_W'(DEPTH - 2);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_ready;
    logic             w_push1;
    logic             w_push2;
    logic [1:0]       w_push_n;
    logic [1:0]       w_pop_n;
    logic [PTR_W-1:0] w_tail2;
    wb_entry_t        w_slot1;
    wb_entry_t        w_slot2;

    assign w_ready  = (r_count <= ACCEPT_MAX);
    assign w_push1  = w_ready && inValid1 && (inReg1 != ZERO_REG);
    assign w_push2  = w_ready && inValid2 && (inReg2 != ZERO_REG);
    assign w_push_n = {1'b0, w_push1} + {1'b0, w_push2};
    assign w_pop_n  = (r_count >= CNT_W'(2)) ? 2'd2 : {1'b0, r_count[0]};
    // Lane 2 lands right behind lane 1, or at tail when lane 1 was dropped.
    assign w_tail2  = r_tail + PTR_W'(w_push1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_n);
            r_tail  <= r_tail + PTR_W'(w_push_n);
            r_count <= r_count - CNT_W'(w_pop_n) + CNT_W'(w_push_n);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_push1) begin
                r_mem[r_tail] <= '{regnum: inReg1, data: inData1};
            end
            if (w_push2) begin
                r_mem[w_tail2] <= '{regnum: inReg2, data: inData2};
            end
        end
    end

    assign w_slot1 = r_mem[r_head];
    assign w_slot2 = r_mem[r_head + PTR_W'(1)];

    assign inReady       = w_ready;
    assign count         = r_count;
    assign RegWriteSign1 = !reset && (r_count != '0);
    assign RegWriteSign2 = !reset && (r_count >= CNT_W'(2));
    assign writeReg1     = RegWriteSign1 ? w_slot1.regnum : '0;
    assign writeData1    = RegWriteSign1 ? w_slot1.data   : '0;
    assign writeReg2     = RegWriteSign2 ? w_slot2.regnum : '0;
    assign writeData2    = RegWriteSign2 ? w_slot2.data   : '0;

    logic [ADDR_W-1:0] w_fwd_reg  [2];
    logic              w_fwd_hit  [2];
    logic [DATA_W-1:0] w_fwd_data [2];

    assign w_fwd_reg[0] = fwdReg1;
    assign w_fwd_reg[1] = fwdReg2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            mips_wb_fwd_match #(.DEPTH(DEPTH)) u_match (
                .i_head    (r_head),
                .i_count   (r_count),
                .i_reg     (w_fwd_reg[gi]),
                .i_entries (r_mem),
                .o_hit     (w_fwd_hit[gi]),
                .o_data    (w_fwd_data[gi])
            );
        end
    endgenerate

    assign fwdHit1  = !reset && w_fwd_hit[0];
    assign fwdHit2  = !reset && w_fwd_hit[1];
    assign fwdData1 = reset ? '0 : w_fwd_data[0];
    assign fwdData2 = reset ? '0 : w_fwd_data[1];
endmodule

// File: tb/tb_mips_writeback_buffer.sv
// Bench for mips_writeback_buffer: a DEPTH=4 and a DEPTH=2 instance share stimulus,
// each checked every cycle against a queue model, plus directed literal expectations.
module tb_mips_writeback_buffer;
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inValid1 = 1'b0, inValid2 = 1'b0;
    logic [4:0]  inReg1 = '0, inReg2 = '0;
    logic [31:0] inData1 = '0, inData2 = '0;
    logic [4:0]  fwdReg1 = '0, fwdReg2 = '0;
    logic        checking = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            localparam int D = (gi == 0) ? 4 : 2;
            logic              ready, s1, s2, fh1, fh2;
            logic [4:0]        wr1, wr2;
            logic [31:0]       wd1, wd2, fd1, fd2;
            logic [$clog2(D):0] cnt;
            ent_t              q[$];

            mips_writeback_buffer #(.DEPTH(D), .DATA_W(32), .ADDR_W(5)) dut (
                .clock(clock), .reset(reset),
                .inValid1(inValid1), .inValid2(inValid2),
                .inReg1(inReg1), .inReg2(inReg2),
                .inData1(inData1), .inData2(inData2),
                .inReady(ready),
                .RegWriteSign1(s1), .RegWriteSign2(s2),
                .writeReg1(wr1), .writeReg2(wr2),
                .writeData1(wd1), .writeData2(wd2),
                .fwdReg1(fwdReg1), .fwdReg2(fwdReg2),
                .fwdHit1(fh1), .fwdHit2(fh2),
                .fwdData1(fd1), .fwdData2(fd2),
                .count(cnt)
            );

            // Model: retire up to two oldest, then accept lanes in order if room existed.
            always @(posedge clock) begin
                ent_t e;
                int   n;
                bit   rdy;
                if (reset) begin
                    q.delete();
                end else begin
                    rdy = (D - q.size()) >= 2;
                    n = (q.size() < 2) ? q.size() : 2;
                    for (int k = 0; k < n; k++) void'(q.pop_front());
                    if (rdy && inValid1 && inReg1 != 5'd0) begin
                        e.r = inReg1; e.d = inData1; q.push_back(e);
                        if (gi == 0) $display("depth%0d push r%0d d%h", D, inReg1, inData1);
                    end
                    if (rdy && inValid2 && inReg2 != 5'd0) begin
                        e.r = inReg2; e.d = inData2; q.push_back(e);
                        if (gi == 0) $display("depth%0d push r%0d d%h", D, inReg2, inData2);
                    end
                end
            end

            always @(negedge clock) begin
                logic        e_s1, e_s2, e_h1, e_h2;
                logic [4:0]  e_r1, e_r2;
                logic [31:0] e_d1, e_d2, e_f1, e_f2;
                int          sz;
                if (checking) begin
                    sz   = q.size();
                    e_s1 = !reset && sz >= 1;
                    e_s2 = !reset && sz >= 2;
                    e_r1 = e_s1 ? q[0].r : 5'd0;
                    e_d1 = e_s1 ? q[0].d : 32'd0;
                    e_r2 = e_s2 ? q[1].r : 5'd0;
                    e_d2 = e_s2 ? q[1].d : 32'd0;
                    e_h1 = 1'b0; e_f1 = 32'd0;
                    e_h2 = 1'b0; e_f2 = 32'd0;
                    for (int i = sz - 1; i >= 0; i--) begin
                        if (!e_h1 && fwdReg1 != 5'd0 && q[i].r == fwdReg1) begin
                            e_h1 = 1'b1; e_f1 = q[i].d;
                        end
                        if (!e_h2 && fwdReg2 != 5'd0 && q[i].r == fwdReg2) begin
                            e_h2 = 1'b1; e_f2 = q[i].d;
                        end
                    end
                    if (reset) begin
                        e_h1 = 1'b0; e_f1 = 32'd0; e_h2 = 1'b0; e_f2 = 32'd0;
                    end
                    chk($sformatf("d%0d_count", D), 32'(cnt), 32'(sz));
                    chk($sformatf("d%0d_ready", D), 32'(ready), 32'((D - sz) >= 2));
                    chk($sformatf("d%0d_we1", D), 32'(s1), 32'(e_s1));
                    chk($sformatf("d%0d_we2", D), 32'(s2), 32'(e_s2));
                    chk($sformatf("d%0d_wreg1", D), 32'(wr1), 32'(e_r1));
                    chk($sformatf("d%0d_wreg2", D), 32'(wr2), 32'(e_r2));
                    chk($sformatf("d%0d_wdata1", D), wd1, e_d1);
                    chk($sformatf("d%0d_wdata2", D), wd2, e_d2);
                    chk($sformatf("d%0d_fhit1", D), 32'(fh1), 32'(e_h1));
                    chk($sformatf("d%0d_fhit2", D), 32'(fh2), 32'(e_h2));
                    chk($sformatf("d%0d_fdata1", D), fd1, e_f1);
                    chk($sformatf("d%0d_fdata2", D), fd2, e_f2);
                end
            end
        end
    endgenerate

    task automatic drive(input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                         input logic v2, input logic [4:0] r2, input logic [31:0] d2);
        #1;
        inValid1 = v1; inReg1 = r1; inData1 = d1;
        inValid2 = v2; inReg2 = r2; inData2 = d2;
    endtask

    initial begin
        @(posedge clock);
        @(negedge clock);
        chk("rst_count", 32'(g_inst[0].cnt), 32'd0);
        chk("rst_we1", 32'(g_inst[0].s1), 32'd0);
        #1 reset = 1'b0;
        checking = 1'b1;
        chk("rst_ready", 32'(g_inst[0].ready), 32'd1);

        // Single lane-1 result
        drive(1, 5'd3, 32'hAAAA_0001, 0, 5'd0, 32'd0);
        @(negedge clock);
        chk("t1_we1", 32'(g_inst[0].s1), 32'd1);
        chk("t1_wreg1", 32'(g_inst[0].wr1), 32'd3);
        chk("t1_wdata1", g_inst[0].wd1, 32'hAAAA_0001);
        chk("t1_we2", 32'(g_inst[0].s2), 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        @(negedge clock);
        chk("t1_drained", 32'(g_inst[0].cnt), 32'd0);

        // Same register on both lanes: younger on port 2 and forwarded
        fwdReg1 = 5'd7;
        drive(1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
        @(negedge clock);
        chk("t2_wreg1", 32'(g_inst[0].wr1), 32'd7);
        chk("t2_wdata1", g_inst[0].wd1, 32'h11);
        chk("t2_wreg2", 32'(g_inst[0].wr2), 32'd7);
        chk("t2_wdata2", g_inst[0].wd2, 32'h22);
        chk("t2_fhit1", 32'(g_inst[0].fh1), 32'd1);
        chk("t2_fdata1", g_inst[0].fd1, 32'h22);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        @(negedge clock);
        chk("t2_fmiss", 32'(g_inst[0].fh1), 32'd0);

        // Register-0 result discarded
        fwdReg1 = 5'd0; fwdReg2 = 5'd9;
        drive(1, 5'd0, 32'h33, 1, 5'd9, 32'h99);
        @(negedge clock);
        chk("t3_count", 32'(g_inst[0].cnt), 32'd1);
        chk("t3_wreg1", 32'(g_inst[0].wr1), 32'd9);
        chk("t3_fhit_r0", 32'(g_inst[0].fh1), 32'd0);
        chk("t3_fdata2", g_inst[0].fd2, 32'h99);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        @(negedge clock);

        // Streaming two per cycle; the DEPTH=2 instance alternates accept/stall
        fwdReg1 = 5'd12; fwdReg2 = 5'd25;
        for (int k = 0; k < 6; k++) begin
            drive(1, 5'(10 + k), 32'h100 + k, 1, 5'(20 + k), 32'h200 + k);
            @(negedge clock);
            chk("t4_ready", 32'(g_inst[0].ready), 32'd1);
            chk("t4_order1", 32'(g_inst[0].wr1), 32'(10 + k));
            chk("t4_order2", 32'(g_inst[0].wd2), 32'h200 + k);
            if (k == 0) begin
                chk("t5_full_cnt", 32'(g_inst[1].cnt), 32'd2);
                chk("t5_full_ready", 32'(g_inst[1].ready), 32'd0);
            end
            if (k == 1) begin
                chk("t5_drain_cnt", 32'(g_inst[1].cnt), 32'd0);
                chk("t5_drain_ready", 32'(g_inst[1].ready), 32'd1);
            end
        end

        // Reset with two entries pending
        fwdReg1 = 5'd15; fwdReg2 = 5'd25;
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        reset = 1'b1;
        #1;
        chk("t6_cnt_pre", 32'(g_inst[0].cnt), 32'd2);
        chk("t6_we1", 32'(g_inst[0].s1), 32'd0);
        chk("t6_we2", 32'(g_inst[0].s2), 32'd0);
        chk("t6_fhit2", 32'(g_inst[0].fh2), 32'd0);
        @(negedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("t6_cnt_post", 32'(g_inst[0].cnt), 32'd0);
        chk("t6_fhit_post", 32'(g_inst[0].fh1), 32'd0);
        chk("t6_ready_post", 32'(g_inst[0].ready), 32'd1);

        drive(1, 5'd5, 32'h55, 0, 5'd0, 32'd0);
        @(negedge clock);
        chk("t7_wreg1", 32'(g_inst[0].wr1), 32'd5);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        @(negedge clock);
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mips_writeback_buffer.md
# mips_writeback_buffer

Dual-lane result buffer between the execute/memory stages and the two-write-port register file. Accepts up to two register results per cycle, holds them in order in a small circular queue, and retires the two oldest each cycle onto the register file's write ports (RegWriteSign1/2, writeReg1/2, writeData1/2). Provides a youngest-match forwarding lookup so decode sees results still pending in the buffer.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- DATA_W, 32, result width
- ADDR_W, 5, register index width

- clock  in  1  rising-edge clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- inValid1 / inValid2  in  1  result present on lane 1 / lane 2
- inReg1 / inReg2  in  ADDR_W  destination register
- inData1 / inData2  in  DATA_W  result value
- inReady  out  1  buffer accepts both lanes this cycle
- RegWriteSign1 / RegWriteSign2  out  1  write enable to register file port 1 / 2
- writeReg1 / writeReg2  out  ADDR_W  write index
- writeData1 / writeData2  out  DATA_W  write value
- fwdReg1 / fwdReg2  in  ADDR_W  forwarding lookup index
- fwdHit1 / fwdHit2  out  1  a pending entry targets fwdRegN
- fwdData1 / fwdData2  out  DATA_W  youngest pending value for fwdRegN; 0 on miss
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Queue: head pointer, tail pointer, count; pointers wrap modulo DEPTH.
- Retire: RegWriteSign1 = (count ≥ 1), port 1 = entry at head; RegWriteSign2 = (count ≥ 2), port 2 = entry at head+1. Port 2 always carries the younger entry, so a same-register pair resolves younger-wins in the register file.
- When RegWriteSignN = 0, writeRegN and writeDataN are 0.
- Pop: at each posedge, head += min(count, 2).
- Accept: inReady = (DEPTH − count ≥ 2), evaluated on pre-edge count. When inReady = 0, inputs are ignored; upstream holds them.
- Enqueue at posedge when inReady: lane 1 before lane 2 (lane 1 is older). A lane is stored only if inValidN = 1 and inRegN ≠ 0; register-0 results are discarded. 0, 1 or 2 entries are written at tail; tail += number stored.
- count_next = count − pop + push; simultaneous pop and push are always legal.
- Forwarding (combinational): scan occupied entries from youngest to oldest; first entry with reg == fwdRegN gives fwdHitN = 1, fwdDataN = its data. fwdRegN = 0 never hits. Entries on the write ports this cycle still hit until popped.

## Timing
- Reset (reset high at posedge): count = 0, head = tail = 0, contents dropped. While reset is high, all RegWriteSignN, writeRegN, writeDataN, fwdHitN and fwdDataN are forced to 0. After reset, inReady = 1.
- Reset mid-operation: pending entries are lost. No write is issued in the reset cycle.
- Latency: an entry accepted at posedge N drives its write port during cycle N if it is among the two oldest. The register file writes it at the following negedge, and it is popped at posedge N+1. Minimum latency is 1 cycle; throughput is 2 results per cycle.
- Full: count = DEPTH − 1 or DEPTH gives inReady = 0. Pop still proceeds, so inReady returns on the next cycle.
- Empty: both RegWriteSign low; fwdHit low.

## Structure
- Shared package mips_pkg: REG_ADDR_W = 5, DATA_W = 32, ZERO_REG = 5'd0, and the wb_entry_t struct {reg, data}.
- Sub-module mips_wb_fwd_match: youngest-first priority search over entry array given head and count; instantiated twice (one per lookup port).

## Test plan
- Reset, then inValid1 = 1, inReg1 = 3, inData1 = 0xAAAA_0001 → next cycle RegWriteSign1 = 1, writeReg1 = 3, writeData1 = 0xAAAA_0001, RegWriteSign2 = 0; count returns to 0 one cycle later.
- Both lanes to reg 7: lane 1 = 0x11, lane 2 = 0x22 → port 1 = (7, 0x11), port 2 = (7, 0x22); fwdReg1 = 7 gives fwdHit1 = 1, fwdData1 = 0x22 while pending.
- inReg1 = 0, inReg2 = 9 (both valid) → only reg 9 stored; count = 1; fwdReg1 = 0 gives fwdHit1 = 0.
- Fill with DEPTH = 4 and stalled draining impossible (pops 2/cycle): push 2/cycle for 6 cycles → inReady never deasserts; retire order matches issue order exactly.
- Preload count = 3, then assert inValid1/2 → inReady = 0, inputs ignored; next cycle count = 1, inReady = 1.
- Assert reset with count = 2 → in the reset cycle RegWriteSign1/2 = 0; after reset count = 0, fwdHit = 0 for previously pending registers.
